truth_table_engine: RTL and testbench

Programmable N-input single-output Boolean function block that replaces fixed per-table gate netlists with a loadable truth table (LUT). The table is loaded serially, one minterm bit per accepted beat. The block then answers registered point evaluations, or runs a sweep that streams the full truth table and counts its minterms. It sits beside the lab's combinational exercise modules as a generic, clocked evaluator and checker for any SOP/POS/K-map result.

---
 rtl/truth_table_pkg.sv | 20 ++
 rtl/tt_storage.sv | 46 ++++
 rtl/truth_table_engine.sv | 160 ++++++++++++++++
 tb/tb_truth_table_engine.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/truth_table_pkg.sv
// Shared definitions for the loadable truth-table evaluator: FSM states,
// supported input-count range and the table depth derived from it.
package truth_table_pkg;

  localparam int N_IN_MIN = 2;
  localparam int N_IN_MAX = 6;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LOAD  = 2'd1,
    READY = 2'd2,
    SWEEP = 2'd3
  } tt_state_e;

  // Number of minterms of an n-input function.
  function automatic int tt_bits(input int n_in);
    return 32'sd1 <<< n_in;
  endfunction

endpackage

// File: rtl/tt_storage.sv
// TT_BITS x 1 truth-table register array: cleared on reset, one write port,
// independent read ports for point evaluation and for the sweep stream.
module tt_storage
  import truth_table_pkg::*;
#(
  parameter int N_IN = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_en,
  input  logic [N_IN-1:0] wr_idx,
  input  logic            wr_bit,
  input  logic [N_IN-1:0] eval_idx,
  input  logic [N_IN-1:0] sweep_idx,
  output logic            eval_bit,
  output logic            sweep_bit
);

  localparam int TT_BITS = tt_bits(N_IN);

  logic [TT_BITS-1:0] mem_q;
  logic [TT_BITS-1:0] mem_d;

  // Next table contents: a single minterm bit replaced when written.
  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wr_idx] = wr_bit;
    end else begin
      mem_d = mem_q;
    end
  end

  // Table storage, cleared to all zeros by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= {TT_BITS{1'b0}};
    end else begin
      mem_q <= mem_d;
    end
  end

  assign eval_bit  = mem_q[eval_idx];
  assign sweep_bit = mem_q[sweep_idx];

endmodule

// File: rtl/truth_table_engine.sv
// Programmable N_IN-input Boolean function: serial table load, registered
// point evaluation, and a full-table sweep that counts the minterms.
module truth_table_engine
  import truth_table_pkg::*;
#(
  parameter int N_IN = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_valid,
  input  logic            load_bit,
  output logic            load_ready,
  output logic            load_done,
  input  logic            eval_valid,
  input  logic [N_IN-1:0] eval_in,
  output logic            eval_ready,
  output logic            y_valid,
  output logic            y,
  input  logic            sweep_start,
  output logic            sweep_busy,
  output logic            sweep_valid,
  output logic [N_IN-1:0] sweep_idx,
  output logic            sweep_y,
  output logic            sweep_done,
  output logic [N_IN:0]   minterm_count
);

  localparam logic [N_IN-1:0] LAST_IDX = {N_IN{1'b1}};
  localparam logic [N_IN-1:0] IDX_ONE  = {{(N_IN-1){1'b0}}, 1'b1};
  localparam logic [N_IN-1:0] IDX_ZERO = {N_IN{1'b0}};

  tt_state_e       state_q, state_d;
  logic [N_IN-1:0] ptr_q, ptr_d;
  logic [N_IN:0]   run_q, run_d;
  logic [N_IN:0]   mc_q, mc_d;
  logic [N_IN-1:0] sidx_q, sidx_d;
  logic            y_q, y_d, yv_q, yv_d, ld_q, ld_d;
  logic            sv_q, sv_d, sy_q, sy_d, sd_q, sd_d;

  logic            load_acc_s, sweep_acc_s, eval_acc_s;
  logic [N_IN-1:0] sweep_rd_idx_s;
  logic            eval_bit_s, sweep_bit_s;

  // Load beats win over sweep requests, which win over evaluations.
  assign load_acc_s  = load_valid && (state_q != SWEEP);
  assign sweep_acc_s = (state_q == READY) && sweep_start && !load_valid;
  assign eval_acc_s  = (state_q == READY) && eval_valid && !load_valid && !sweep_start;

  // Sweep reads one index ahead so sweep_y is registered alongside sweep_idx.
  assign sweep_rd_idx_s = (state_q == SWEEP) ? (sidx_q + IDX_ONE) : IDX_ZERO;

  tt_storage #(.N_IN(N_IN)) u_storage (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (load_acc_s),
    .wr_idx    (ptr_q),
    .wr_bit    (load_bit),
    .eval_idx  (eval_in),
    .sweep_idx (sweep_rd_idx_s),
    .eval_bit  (eval_bit_s),
    .sweep_bit (sweep_bit_s)
  );

  // Next-state and next-output computation for load, evaluate and sweep.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    run_d   = run_q;
    mc_d    = mc_q;
    sidx_d  = sidx_q;
    y_d     = y_q;
    yv_d    = 1'b0;
    ld_d    = 1'b0;
    sv_d    = sv_q;
    sy_d    = sy_q;
    sd_d    = 1'b0;
    case (state_q)
      EMPTY, LOAD, READY: begin
        if (load_acc_s) begin
          if (ptr_q == LAST_IDX) begin
            ptr_d   = IDX_ZERO;
            state_d = READY;
            ld_d    = 1'b1;
          end else begin
            ptr_d   = ptr_q + IDX_ONE;
            state_d = LOAD;
          end
        end else if (sweep_acc_s) begin
          state_d = SWEEP;
          sidx_d  = IDX_ZERO;
          sv_d    = 1'b1;
          sy_d    = sweep_bit_s;
          run_d   = {(N_IN+1){1'b0}};
        end else if (eval_acc_s) begin
          y_d  = eval_bit_s;
          yv_d = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      SWEEP: begin
        if (sidx_q == LAST_IDX) begin
          state_d = READY;
          sv_d    = 1'b0;
          sd_d    = 1'b1;
          mc_d    = run_q + {{N_IN{1'b0}}, sy_q};
        end else begin
          sidx_d = sidx_q + IDX_ONE;
          sy_d   = sweep_bit_s;
          run_d  = run_q + {{N_IN{1'b0}}, sy_q};
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  // State, pointer, counter and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      ptr_q   <= {N_IN{1'b0}};
      run_q   <= {(N_IN+1){1'b0}};
      mc_q    <= {(N_IN+1){1'b0}};
      sidx_q  <= {N_IN{1'b0}};
      y_q     <= 1'b0;
      yv_q    <= 1'b0;
      ld_q    <= 1'b0;
      sv_q    <= 1'b0;
      sy_q    <= 1'b0;
      sd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      run_q   <= run_d;
      mc_q    <= mc_d;
      sidx_q  <= sidx_d;
      y_q     <= y_d;
      yv_q    <= yv_d;
      ld_q    <= ld_d;
      sv_q    <= sv_d;
      sy_q    <= sy_d;
      sd_q    <= sd_d;
    end
  end

  assign load_ready    = (state_q != SWEEP);
  assign eval_ready    = (state_q == READY);
  assign sweep_busy    = (state_q == SWEEP);
  assign load_done     = ld_q;
  assign y             = y_q;
  assign y_valid       = yv_q;
  assign sweep_valid   = sv_q;
  assign sweep_idx     = sidx_q;
  assign sweep_y       = sy_q;
  assign sweep_done    = sd_q;
  assign minterm_count = mc_q;

endmodule

// File: tb/tb_truth_table_engine.sv
// Bench: three engines (N_IN = 3, 2, 6) share one stimulus stream and are
// compared every cycle against a table-level model of the block.
module tb_truth_table_engine;

  localparam int ND = 3;
  localparam int NF = 11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic lv = 1'b0, lb = 1'b0, ev = 1'b0, ss = 1'b0;
  logic [5:0] ei = 6'd0;

  logic a_lr, a_ld, a_er, a_yv, a_y, a_bs, a_sv, a_sy, a_sd;
  logic [2:0] a_si;
  logic [3:0] a_mc;
  logic b_lr, b_ld, b_er, b_yv, b_y, b_bs, b_sv, b_sy, b_sd;
  logic [1:0] b_si;
  logic [2:0] b_mc;
  logic c_lr, c_ld, c_er, c_yv, c_y, c_bs, c_sv, c_sy, c_sd;
  logic [5:0] c_si;
  logic [6:0] c_mc;

  int checks = 0;
  int failures = 0;
  int pin_req = 0;

  // model state per engine
  bit [63:0] m_tbl [ND];
  int m_mode [ND];  // 0 empty, 1 loading, 2 ready, 3 sweeping
  int m_ptr  [ND];
  int m_spos [ND];
  bit e_y [ND], e_yv [ND], e_ld [ND], e_sv [ND], e_sy [ND], e_sd [ND];
  int e_si [ND], e_mc [ND];

  always #5 clk = ~clk;

  truth_table_engine #(.N_IN(3)) dut_a (
    .clk(clk), .rst_n(rst_n), .load_valid(lv), .load_bit(lb), .load_ready(a_lr),
    .load_done(a_ld), .eval_valid(ev), .eval_in(ei[2:0]), .eval_ready(a_er),
    .y_valid(a_yv), .y(a_y), .sweep_start(ss), .sweep_busy(a_bs), .sweep_valid(a_sv),
    .sweep_idx(a_si), .sweep_y(a_sy), .sweep_done(a_sd), .minterm_count(a_mc));

  truth_table_engine #(.N_IN(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .load_valid(lv), .load_bit(lb), .load_ready(b_lr),
    .load_done(b_ld), .eval_valid(ev), .eval_in(ei[1:0]), .eval_ready(b_er),
    .y_valid(b_yv), .y(b_y), .sweep_start(ss), .sweep_busy(b_bs), .sweep_valid(b_sv),
    .sweep_idx(b_si), .sweep_y(b_sy), .sweep_done(b_sd), .minterm_count(b_mc));

  truth_table_engine #(.N_IN(6)) dut_c (
    .clk(clk), .rst_n(rst_n), .load_valid(lv), .load_bit(lb), .load_ready(c_lr),
    .load_done(c_ld), .eval_valid(ev), .eval_in(ei), .eval_ready(c_er),
    .y_valid(c_yv), .y(c_y), .sweep_start(ss), .sweep_busy(c_bs), .sweep_valid(c_sv),
    .sweep_idx(c_si), .sweep_y(c_sy), .sweep_done(c_sd), .minterm_count(c_mc));

  function automatic int nin(input int d);
    case (d)
      0: return 3;
      1: return 2;
      default: return 6;
    endcase
  endfunction

  function automatic string fname(input int f);
    case (f)
      0: return "load_ready";  1: return "load_done";  2: return "eval_ready";
      3: return "y_valid";     4: return "y";          5: return "sweep_busy";
      6: return "sweep_valid"; 7: return "sweep_idx";  8: return "sweep_y";
      9: return "sweep_done";  default: return "minterm_count";
    endcase
  endfunction

  function automatic int act_field(input int d, input int f);
    int v [NF];
    case (d)
      0: v = '{int'(a_lr), int'(a_ld), int'(a_er), int'(a_yv), int'(a_y), int'(a_bs),
               int'(a_sv), int'(a_si), int'(a_sy), int'(a_sd), int'(a_mc)};
      1: v = '{int'(b_lr), int'(b_ld), int'(b_er), int'(b_yv), int'(b_y), int'(b_bs),
               int'(b_sv), int'(b_si), int'(b_sy), int'(b_sd), int'(b_mc)};
      default: v = '{int'(c_lr), int'(c_ld), int'(c_er), int'(c_yv), int'(c_y), int'(c_bs),
               int'(c_sv), int'(c_si), int'(c_sy), int'(c_sd), int'(c_mc)};
    endcase
    return v[f];
  endfunction

  function automatic int exp_field(input int d, input int f);
    int v [NF];
    if (!rst_n) begin
      v = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    end else begin
      v = '{int'(m_mode[d] != 3), int'(e_ld[d]), int'(m_mode[d] == 2), int'(e_yv[d]),
            int'(e_y[d]), int'(m_mode[d] == 3), int'(e_sv[d]), e_si[d], int'(e_sy[d]),
            int'(e_sd[d]), e_mc[d]};
    end
    return v[f];
  endfunction

  task automatic chk(input string nm, input int d, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s n_in=%0d t=%0t actual=%0d expected=%0d", nm, nin(d), $time, act, exp);
    end
  endtask

  // Behavioural model: advances each engine's table-level view on every edge.
  always @(posedge clk) begin
    for (int d = 0; d < ND; d++) begin
      int tt;
      tt = 1 << nin(d);
      if (!rst_n) begin
        m_tbl[d] = 64'd0; m_mode[d] = 0; m_ptr[d] = 0; m_spos[d] = 0;
        e_y[d] = 1'b0; e_yv[d] = 1'b0; e_ld[d] = 1'b0; e_sv[d] = 1'b0;
        e_sy[d] = 1'b0; e_sd[d] = 1'b0; e_si[d] = 0; e_mc[d] = 0;
      end else begin
        e_yv[d] = 1'b0; e_ld[d] = 1'b0; e_sd[d] = 1'b0;
        if (m_mode[d] == 3) begin
          if (m_spos[d] == tt - 1) begin
            int cnt;
            cnt = 0;
            for (int i = 0; i < tt; i++) cnt += int'(m_tbl[d][i]);
            m_mode[d] = 2; e_sv[d] = 1'b0; e_sd[d] = 1'b1; e_mc[d] = cnt;
          end else begin
            m_spos[d]++;
            e_si[d] = m_spos[d]; e_sy[d] = m_tbl[d][m_spos[d]];
          end
        end else if (lv) begin
          m_tbl[d][m_ptr[d]] = lb;
          m_ptr[d]++;
          if (m_ptr[d] == tt) begin
            m_ptr[d] = 0; m_mode[d] = 2; e_ld[d] = 1'b1;
          end else begin
            m_mode[d] = 1;
          end
        end else if (m_mode[d] == 2 && ss) begin
          m_mode[d] = 3; m_spos[d] = 0; e_sv[d] = 1'b1; e_si[d] = 0; e_sy[d] = m_tbl[d][0];
        end else if (m_mode[d] == 2 && ev) begin
          e_y[d] = m_tbl[d][int'(ei) % tt]; e_yv[d] = 1'b1;
        end
      end
    end
  end

  // Compare process: model versus DUT every cycle, plus literal pins.
  always @(negedge clk) begin
    for (int d = 0; d < ND; d++) begin
      for (int f = 0; f < NF; f++) begin
        if (!((f == 7 || f == 8) && rst_n && !e_sv[d]))
          chk(fname(f), d, act_field(d, f), exp_field(d, f));
      end
    end
    case (pin_req)
      1: begin
        chk("pin_maj_count", 0, int'(a_mc), 4);  chk("pin_maj_count_model", 0, e_mc[0], 4);
        chk("pin_or_count", 1, int'(b_mc), 3);   chk("pin_or_count_model", 1, e_mc[1], 3);
        chk("pin_maj_done", 0, int'(a_sd), 1);
      end
      2: begin
        chk("pin_ones_count", 2, int'(c_mc), 64); chk("pin_ones_count_model", 2, e_mc[2], 64);
        chk("pin_ones_count", 0, int'(a_mc), 8);  chk("pin_ones_count", 1, int'(b_mc), 4);
      end
      3: begin
        chk("pin_eval101_y", 0, int'(a_y), 1);   chk("pin_eval101_y_model", 0, int'(e_y[0]), 1);
        chk("pin_eval101_valid", 0, int'(a_yv), 1);
      end
      4: begin
        chk("pin_eval100_y", 0, int'(a_y), 0);   chk("pin_eval100_y_model", 0, int'(e_y[0]), 0);
        chk("pin_eval100_valid", 0, int'(a_yv), 1);
      end
      5: begin
        chk("pin_post_reset_eval_ready", 0, int'(a_er), 0);
        chk("pin_post_reset_load_ready", 0, int'(a_lr), 1);
      end
      6: begin
        chk("pin_reset_sweep_valid", 0, int'(a_sv), 0); chk("pin_reset_busy", 0, int'(a_bs), 0);
        chk("pin_reset_sweep_done", 0, int'(a_sd), 0);  chk("pin_reset_count", 0, int'(a_mc), 0);
        chk("pin_reset_sweep_idx", 0, int'(a_si), 0);
      end
      7: begin
        chk("pin_load_done", 0, int'(a_ld), 1); chk("pin_load_done_model", 0, int'(e_ld[0]), 1);
      end
      8: begin
        chk("pin_empty_eval_ready", 0, int'(a_er), 0); chk("pin_empty_y_valid", 0, int'(a_yv), 0);
        chk("pin_empty_load_ready", 0, int'(a_lr), 1); chk("pin_empty_count", 0, int'(a_mc), 0);
      end
      9: begin
        chk("pin_prio_busy", 0, int'(a_bs), 0); chk("pin_prio_y_valid", 0, int'(a_yv), 0);
        chk("pin_prio_eval_ready", 0, int'(a_er), 0);
      end
      default: ;
    endcase
  end

  task automatic cyc(input logic l_v, input logic l_b, input logic e_v,
                     input logic [5:0] e_i, input logic s_s);
    lv = l_v; lb = l_b; ev = e_v; ei = e_i; ss = s_s;
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [7:0] maj;
    maj = 8'hE8;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;

    // evaluation requests while empty are not accepted
    cyc(1'b0, 1'b0, 1'b1, 6'd5, 1'b0);
    pin_req = 8;
    cyc(1'b0, 1'b0, 1'b1, 6'd5, 1'b0);
    pin_req = 0;

    // majority table with an idle gap mid-load
    for (int i = 0; i < 8; i++) begin
      if (i == 3) cyc(1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
      cyc(1'b1, maj[i], 1'b0, 6'd0, 1'b0);
    end
    pin_req = 7;
    cyc(1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
    pin_req = 0;

    // back-to-back evaluations
    cyc(1'b0, 1'b0, 1'b1, 6'd5, 1'b0);
    pin_req = 3;
    cyc(1'b0, 1'b0, 1'b1, 6'd4, 1'b0);
    pin_req = 4;
    cyc(1'b0, 1'b0, 1'b1, 6'd3, 1'b0);
    pin_req = 0;
    cyc(1'b0, 1'b0, 1'b0, 6'd0, 1'b0);

    // sweep with evaluation requests that must be dropped
    cyc(1'b0, 1'b0, 1'b0, 6'd0, 1'b1);
    repeat (8) cyc(1'b0, 1'b0, 1'b1, 6'd7, 1'b0);
    pin_req = 1;
    cyc(1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
    pin_req = 0;

    // load, sweep and eval in the same cycle: load wins
    cyc(1'b1, 1'b1, 1'b1, 6'd2, 1'b1);
    pin_req = 9;
    cyc(1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
    pin_req = 0;

    // reset, then an all-ones table and a held sweep_start
    rst_n = 1'b0;
    repeat (2) cyc(1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
    rst_n = 1'b1;
    repeat (64) cyc(1'b1, 1'b1, 1'b0, 6'd0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
    repeat (70) cyc(1'b0, 1'b0, 1'b0, 6'd0, 1'b1);
    pin_req = 2;
    cyc(1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
    pin_req = 0;
    repeat (70) cyc(1'b0, 1'b0, 1'b0, 6'd0, 1'b0);

    // reset asserted while the 3-input sweep shows index 3
    cyc(1'b0, 1'b0, 1'b0, 6'd0, 1'b1);
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
    rst_n = 1'b0;
    pin_req = 6;
    cyc(1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
    pin_req = 0;
    cyc(1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
    rst_n = 1'b1;
    pin_req = 5;
    cyc(1'b0, 1'b0, 1'b1, 6'd1, 1'b0);
    pin_req = 0;

    // randomized traffic with occasional resets
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 1'b0;
        repeat (2) cyc(1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
        rst_n = 1'b1;
      end else begin
        cyc(1'($urandom_range(0, 9) < 3), 1'($urandom()), 1'($urandom()),
            6'($urandom()), 1'($urandom_range(0, 9) == 0));
      end
    end
    cyc(1'b0, 1'b0, 1'b0, 6'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
